// File: rtl/wb_stage_p.sv
// MEM/WB pipeline register with stall/flush, sub-word load formatting and write-back select.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_p #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned PC_INC  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [XLEN-1:0]    in_aluout,
  input  logic [XLEN-1:0]    in_mem_data,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [1:0]         in_wdsel,
  input  logic [2:0]         in_dmtype,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_regwrite,
  output logic               wb_valid,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_wd
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_cnt
`endif
);

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    aluout_q, aluout_d;
  logic [XLEN-1:0]    mem_data_q, mem_data_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic [1:0]         wdsel_q, wdsel_d;
  logic [2:0]         dmtype_q, dmtype_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               regwrite_q, regwrite_d;

  logic               advance;
  logic [1:0]         off;
  logic [15:0]        half_sel;
  logic [7:0]         byte_sel;
  logic [XLEN-1:0]    load_data;

  // Flush also advances the stage so a bubble replaces whatever was held.
  assign advance = flush | ~stall;

  always_comb begin
    valid_d    = valid_q;
    aluout_d   = aluout_q;
    mem_data_d = mem_data_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    wdsel_d    = wdsel_q;
    dmtype_d   = dmtype_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    if (advance) begin
      valid_d    = in_valid;
      aluout_d   = in_aluout;
      mem_data_d = in_mem_data;
      pc_d       = in_pc;
      imm_d      = in_imm;
      wdsel_d    = in_wdsel;
      dmtype_d   = in_dmtype;
      rd_d       = in_rd;
      regwrite_d = in_regwrite;
    end
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= 1'b0;
      aluout_q   <= '0;
      mem_data_q <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      wdsel_q    <= '0;
      dmtype_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      aluout_q   <= aluout_d;
      mem_data_q <= mem_data_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      wdsel_q    <= wdsel_d;
      dmtype_q   <= dmtype_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
    end
  end

  // Misaligned halves silently use the aligned half (off[0] ignored).
  assign off      = aluout_q[1:0];
  assign half_sel = mem_data_q[{off[1], 4'b0000} +: 16];
  assign byte_sel = mem_data_q[{off, 3'b000} +: 8];

  always_comb begin
    load_data = XLEN'($signed(mem_data_q[31:0]));
    case (dmtype_q)
      3'b001:  load_data = XLEN'($signed(half_sel));
      3'b010:  load_data = XLEN'(half_sel);
      3'b011:  load_data = XLEN'($signed(byte_sel));
      3'b100:  load_data = XLEN'(byte_sel);
      default: load_data = XLEN'($signed(mem_data_q[31:0]));
    endcase
  end

  always_comb begin
    wb_wd = aluout_q;
    unique case (wdsel_q)
      2'b00: wb_wd = aluout_q;
      2'b01: wb_wd = load_data;
      2'b10: wb_wd = pc_q + XLEN'(PC_INC);
      2'b11: wb_wd = imm_q;
    endcase
  end

  assign wb_valid = valid_q;
  assign wb_rd    = rd_q;
  assign wb_we    = valid_q & regwrite_q & (rd_q != '0);

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_cnt_q <= '0;
    end else if (advance && valid_q) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_p.sv
// Bench for wb_stage_p: directed vector table, stall/flush/reset sequences and random traffic
// checked against a behavioural model.
module tb_wb_stage_p;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, flush;
  logic        in_valid, in_regwrite;
  logic [31:0] in_aluout, in_mem_data, in_pc, in_imm;
  logic [1:0]  in_wdsel;
  logic [2:0]  in_dmtype;
  logic [4:0]  in_rd;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  wb_stage_p #(.XLEN(32), .RADDR_W(5), .PC_INC(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_aluout   (in_aluout),
    .in_mem_data (in_mem_data),
    .in_pc       (in_pc),
    .in_imm      (in_imm),
    .in_wdsel    (in_wdsel),
    .in_dmtype   (in_dmtype),
    .in_rd       (in_rd),
    .in_regwrite (in_regwrite),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_wd       (wb_wd)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [1:0]  wdsel;
    logic [2:0]  dmtype;
    logic [4:0]  rd;
    logic        rw;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  // Model state: what the stage should currently hold.
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] lim;
    lim = 32'd1 << (bits - 1);
    return (v >= lim) ? v - (lim << 1) : v;
  endfunction

  function automatic logic [31:0] model_wd(input logic [31:0] alu, input logic [31:0] mem,
                                          input logic [31:0] pc, input logic [31:0] imm,
                                          input logic [1:0] wdsel, input logic [2:0] dmtype);
    int          off;
    logic [31:0] h, b;
    off = int'(alu % 4);
    h   = (mem >> (16 * (off / 2))) & 32'hFFFF;
    b   = (mem >> (8 * off)) & 32'hFF;
    case (wdsel)
      2'd0: return alu;
      2'd2: return pc + 32'd4;
      2'd3: return imm;
      default: begin
        if (dmtype == 3'd1) return sext(h, 16);
        if (dmtype == 3'd2) return h;
        if (dmtype == 3'd3) return sext(b, 8);
        if (dmtype == 3'd4) return b;
        return mem;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_rw    = 1'b0;
    m_rd    = '0;
    m_wd    = '0;
    m_cnt   = '0;
  endtask

  task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [1:0] ws,
                        input logic [2:0] dt, input logic [4:0] rd, input logic rw);
    in_valid = v; in_aluout = alu; in_mem_data = mem; in_pc = pc; in_imm = imm;
    in_wdsel = ws; in_dmtype = dt; in_rd = rd; in_regwrite = rw;
  endtask

  // One clock edge with model update, then compare every observable output.
  task automatic step(input string name);
    if ((flush || !stall) && m_valid) m_cnt = m_cnt + 32'd1;
    if (flush) begin
      m_valid = 1'b0;
      m_rw    = 1'b0;
    end else if (!stall) begin
      m_valid = in_valid;
      m_rw    = in_regwrite;
      m_rd    = in_rd;
      m_wd    = model_wd(in_aluout, in_mem_data, in_pc, in_imm, in_wdsel, in_dmtype);
    end
    @(posedge clk);
    #1;
    chk({name, ".valid"}, 32'(wb_valid), 32'(m_valid));
    chk({name, ".we"}, 32'(wb_we), 32'(m_valid & m_rw & (m_rd != 0)));
    if (m_valid) begin
      chk({name, ".rd"}, 32'(wb_rd), 32'(m_rd));
      chk({name, ".wd"}, wb_wd, m_wd);
    end
`ifdef WB_RETIRE_CNT_EN
    chk({name, ".cnt"}, retire_cnt, m_cnt);
`endif
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".valid"}, 32'(wb_valid), 32'd0);
    chk({name, ".we"}, 32'(wb_we), 32'd0);
    chk({name, ".rd"}, 32'(wb_rd), 32'd0);
    chk({name, ".wd"}, wb_wd, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"alu_rd5",   1, 32'h12345678, 0, 0, 0, 2'b00, 3'b000, 5, 1, 1, 32'h12345678};
    vecs[1]  = '{"alu_rd0",   1, 32'h12345678, 0, 0, 0, 2'b00, 3'b000, 0, 1, 0, 32'h12345678};
    vecs[2]  = '{"lb_off3",   1, 32'd3, 32'h80FF7F01, 0, 0, 2'b01, 3'b011, 9, 1, 1, 32'hFFFFFF80};
    vecs[3]  = '{"lbu_off3",  1, 32'd3, 32'h80FF7F01, 0, 0, 2'b01, 3'b100, 9, 1, 1, 32'h00000080};
    vecs[4]  = '{"lh_off2",   1, 32'd2, 32'h80FF7F01, 0, 0, 2'b01, 3'b001, 9, 1, 1, 32'hFFFF80FF};
    vecs[5]  = '{"lhu_off0",  1, 32'd0, 32'h80FF7F01, 0, 0, 2'b01, 3'b010, 9, 1, 1, 32'h00007F01};
    vecs[6]  = '{"lh_off1",   1, 32'd1, 32'h80FF7F01, 0, 0, 2'b01, 3'b001, 9, 1, 1, 32'h00007F01};
    vecs[7]  = '{"lw_code7",  1, 32'd0, 32'h80FF7F01, 0, 0, 2'b01, 3'b111, 9, 1, 1, 32'h80FF7F01};
    vecs[8]  = '{"pc_link",   1, 0, 0, 32'h00000100, 0, 2'b10, 3'b000, 1, 1, 1, 32'h00000104};
    vecs[9]  = '{"pc_wrap",   1, 0, 0, 32'hFFFFFFFC, 0, 2'b10, 3'b000, 1, 1, 1, 32'h00000000};
    vecs[10] = '{"imm_lui",   1, 0, 0, 0, 32'hABCDE000, 2'b11, 3'b000, 31, 1, 1, 32'hABCDE000};

    // Reset with random inputs, then release without an edge.
    rstn = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(1'b1, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 3'($urandom),
           5'($urandom), 1'b1);
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk_reset_outputs("post_release");
`ifdef WB_RETIRE_CNT_EN
    chk("reset.cnt", retire_cnt, 32'd0);
`endif
    @(negedge clk);

    foreach (vecs[i]) begin
      set_in(vecs[i].valid, vecs[i].alu, vecs[i].mem, vecs[i].pc, vecs[i].imm,
             vecs[i].wdsel, vecs[i].dmtype, vecs[i].rd, vecs[i].rw);
      step(vecs[i].name);
      chk({vecs[i].name, ".tbl_we"}, 32'(wb_we), 32'(vecs[i].exp_we));
      chk({vecs[i].name, ".tbl_wd"}, wb_wd, vecs[i].exp_wd);
      chk({vecs[i].name, ".tbl_rd"}, 32'(wb_rd), 32'(vecs[i].rd));
    end

    // Load A, hold it through three stalled edges while inputs change.
    set_in(1'b1, 32'h0000_00AA, 0, 0, 0, 2'b00, 3'b000, 5'd7, 1'b1);
    step("load_a");
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 3'($urandom),
             5'($urandom), 1'b1);
      step("stall_hold");
      chk("stall_hold.wd_a", wb_wd, 32'h0000_00AA);
      chk("stall_hold.rd_a", 32'(wb_rd), 32'd7);
    end
    flush = 1'b1;
    step("stall_flush");
    chk("stall_flush.we", 32'(wb_we), 32'd0);
    stall = 1'b0; flush = 1'b0;
    set_in(1'b1, 32'h0000_0BBB, 0, 0, 0, 2'b00, 3'b000, 5'd12, 1'b1);
    step("after_flush");
    chk("after_flush.wd_b", wb_wd, 32'h0000_0BBB);

    // Asynchronous reset mid-cycle, away from any edge.
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("async_reset");
`ifdef WB_RETIRE_CNT_EN
    chk("async_reset.cnt", retire_cnt, 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    set_in(1'b1, 32'h0000_0CCC, 0, 0, 0, 2'b00, 3'b000, 5'd3, 1'b1);
    step("first_after_reset");

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_in(1'($urandom), $urandom, $urandom, $urandom, $urandom, 2'($urandom),
             3'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
